// File: rtl/arb_mux_rr_if.sv
// rtl/arb_mux_rr_if.sv - request/response bundle between producers, the arbitrating mux and its consumer
interface arb_mux_rr_if #(
  parameter int InputWidth = 4,
  parameter int DataWidth  = 8,
  parameter int IdxWidth   = $clog2(InputWidth)
);
  logic [InputWidth-1:0]                in_valid_i;
  logic [InputWidth-1:0]                in_last_i;
  logic [InputWidth-1:0][DataWidth-1:0] in_data_i;
  logic [InputWidth-1:0]                in_ready_o;
  logic                                 out_valid_o;
  logic [DataWidth-1:0]                 out_data_o;
  logic [IdxWidth-1:0]                  out_idx_o;
  logic                                 out_last_o;
  logic                                 out_ready_i;

  // environment side: producers drive requests, consumer drives out_ready_i
  modport master (
    output in_valid_i, in_last_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o
  );

  // arbiter side
  modport slave (
    input  in_valid_i, in_last_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o
  );
endinterface

// File: rtl/arb_mux_rr.sv
// rtl/arb_mux_rr.sv - registered N-channel arbitrating mux, fixed priority or round-robin, with packet lock
module arb_mux_rr #(
  parameter int InputWidth = 4,
  parameter int DataWidth  = 8,
  parameter int RoundRobin = 1,
  parameter int IdxWidth   = $clog2(InputWidth)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  arb_mux_rr_if.slave bus
);

  logic                  out_valid_q, out_valid_d;
  logic [DataWidth-1:0]  out_data_q, out_data_d;
  logic [IdxWidth-1:0]   out_idx_q, out_idx_d;
  logic                  out_last_q, out_last_d;
  logic [IdxWidth-1:0]   ptr_q, ptr_d;
  logic                  lock_q, lock_d;
  logic [IdxWidth-1:0]   lock_idx_q, lock_idx_d;

  logic                  slot_free;
  logic [InputWidth-1:0] req;
  logic [InputWidth-1:0] req_hi;
  logic [InputWidth-1:0] first_all;
  logic [InputWidth-1:0] first_hi;
  logic [InputWidth-1:0] grant;
  logic [InputWidth-1:0] ready;
  logic [IdxWidth-1:0]   grant_idx;
  logic [DataWidth-1:0]  sel_data;
  logic                  sel_last;
  logic                  xfer;

  // Eligible requests: only the lock owner while a packet is open; req_hi keeps those at or above the pointer
  always_comb begin
    req    = bus.in_valid_i;
    req_hi = '0;
    if (lock_q) begin
      req = bus.in_valid_i & (InputWidth'(1) << lock_idx_q);
    end
    for (int i = 0; i < InputWidth; i++) begin
      req_hi[i] = req[i] && (i >= int'(ptr_q));
    end
  end

  // Lowest set bit picks the winner; round-robin wraps to the overall lowest when nothing sits above the pointer
  always_comb begin
    first_all = req & (~req + InputWidth'(1));
    first_hi  = req_hi & (~req_hi + InputWidth'(1));
    grant     = first_all;
    if ((RoundRobin != 0) && (req_hi != '0)) begin
      grant = first_hi;
    end
  end

  // Encode the one-hot grant and steer the winning beat
  always_comb begin
    grant_idx = '0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < InputWidth; i++) begin
      if (grant[i]) begin
        grant_idx = IdxWidth'(i);
        sel_data  = bus.in_data_i[i];
        sel_last  = bus.in_last_i[i];
      end
    end
  end

  // Ready is withheld during reset so nothing is accepted into a register that is being cleared
  assign slot_free      = ~out_valid_q | bus.out_ready_i;
  assign ready          = grant & {InputWidth{slot_free & rst_ni}};
  assign xfer           = |ready;
  assign bus.in_ready_o = ready;

  // Next state: load on transfer, drop valid on a bare pop, update lock and pointer at packet boundaries
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_idx_d   = grant_idx;
      out_last_d  = sel_last;
      if (sel_last) begin
        lock_d = 1'b0;
        if (RoundRobin != 0) begin
          // explicit compare so non-power-of-two channel counts wrap correctly
          ptr_d = (int'(grant_idx) == InputWidth - 1) ? '0 : grant_idx + IdxWidth'(1);
        end
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = grant_idx;
      end
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_idx_o   = out_idx_q;
  assign bus.out_last_o  = out_last_q;

  // At most one producer is ever offered the slot
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(bus.in_ready_o));

  // A stalled beat must not change under the consumer
  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_q && !bus.out_ready_i) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_idx_q) && $stable(out_last_q)));

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb/tb_arb_mux_rr.sv - scoreboard bench for arb_mux_rr, fixed-priority and round-robin instances
module tb_arb_mux_rr;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]      valid  [2];
  logic [N-1:0]      last   [2];
  logic [N-1:0][7:0] data   [2];
  logic              oready [2];
  logic [N-1:0]      rdy    [2];
  logic              ovalid [2];
  logic              olast  [2];
  logic [7:0]        odata  [2];
  logic [1:0]        oidx   [2];

  int tests = 0;
  int fails = 0;
  int log0[$];
  int log1[$];

  int          rem [2][N];
  logic [N-1:0] hs [2];
  bit          draining;

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic check_log(input string nm, input int got[$], input int exp[$]);
    check({nm, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s beat %0d", nm, i), (i < got.size()) ? got[i] : -1, exp[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // d=0: fixed priority, d=1: round-robin
  for (genvar g = 0; g < 2; g++) begin : g_dut
    arb_mux_rr_if #(.InputWidth(N), .DataWidth(8)) bus ();

    arb_mux_rr #(.InputWidth(N), .DataWidth(8), .RoundRobin(g)) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
    );

    assign bus.in_valid_i  = valid[g];
    assign bus.in_last_i   = last[g];
    assign bus.in_data_i   = data[g];
    assign bus.out_ready_i = oready[g];
    assign rdy[g]          = bus.in_ready_o;
    assign ovalid[g]       = bus.out_valid_o;
    assign odata[g]        = bus.out_data_o;
    assign oidx[g]         = bus.out_idx_o;
    assign olast[g]        = bus.out_last_o;

    beat_t exp_q[$];
    bit    m_valid = 1'b0;
    bit    m_lock  = 1'b0;
    int    m_ptr   = 0;
    int    m_lidx  = 0;

    // Reference model: rotating search from the pointer, lock owner only while a packet is open
    always begin : model
      int           gnt;
      logic [N-1:0] erdy;
      beat_t        b;
      @(negedge clk);
      #1;
      gnt = -1;
      if (m_lock) begin
        if (valid[g][m_lidx]) gnt = m_lidx;
      end else begin
        for (int off = 0; off < N; off++) begin
          if (gnt < 0 && valid[g][(m_ptr + off) % N]) gnt = (m_ptr + off) % N;
        end
      end
      erdy = '0;
      if (rst_n && gnt >= 0 && (!m_valid || oready[g])) erdy[gnt] = 1'b1;
      check($sformatf("d%0d in_ready", g), int'(rdy[g]), int'(erdy));
      check($sformatf("d%0d out_valid", g), int'(ovalid[g]), int'(m_valid));
      if (!rst_n) begin
        m_valid = 1'b0;
        m_lock  = 1'b0;
        m_ptr   = 0;
        m_lidx  = 0;
        exp_q.delete();
      end else if (erdy != '0) begin
        b.idx  = 2'(gnt);
        b.data = data[g][gnt];
        b.last = last[g][gnt];
        exp_q.push_back(b);
        m_valid = 1'b1;
        if (b.last) begin
          m_lock = 1'b0;
          if (g == 1) m_ptr = (gnt + 1) % N;
        end else begin
          m_lock = 1'b1;
          m_lidx = gnt;
        end
      end else if (oready[g]) begin
        m_valid = 1'b0;
      end
    end

    // Monitor: the presented beat must match the oldest expected one, popped on handshake
    always begin : monitor
      beat_t h;
      @(negedge clk);
      #1;
      if (rst_n && ovalid[g]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("d%0d unexpected beat", g), 1, 0);
        end else begin
          h = exp_q[0];
          check($sformatf("d%0d out_data", g), int'(odata[g]), int'(h.data));
          check($sformatf("d%0d out_idx", g), int'(oidx[g]), int'(h.idx));
          check($sformatf("d%0d out_last", g), int'(olast[g]), int'(h.last));
          if (oready[g]) begin
            void'(exp_q.pop_front());
            if (g == 0) log0.push_back(int'({oidx[g], odata[g]}));
            else        log1.push_back(int'({oidx[g], odata[g]}));
          end
        end
      end
    end
  end

  // Random producers: hold a request until accepted, packets of 1-3 beats, bubbles only mid-packet
  task automatic rand_cycle();
    tick();
    for (int d = 0; d < 2; d++) begin
      oready[d] = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (hs[d][k]) begin
          rem[d][k]--;
          valid[d][k] = 1'b0;
        end
        if (!valid[d][k]) begin
          if (rem[d][k] == 0 && !draining && $urandom_range(0, 2) == 0) rem[d][k] = $urandom_range(1, 3);
          if (rem[d][k] > 0 && $urandom_range(0, 3) != 0) begin
            valid[d][k] = 1'b1;
            data[d][k]  = 8'($urandom);
            last[d][k]  = (rem[d][k] == 1);
          end
        end
      end
    end
    #2;
    for (int d = 0; d < 2; d++) hs[d] = valid[d] & rdy[d];
  endtask

  initial begin
    int  e[$];
    int  sent;
    bit  done;

    rst_n    = 1'b0;
    draining = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid[d]  = '1;
      last[d]   = '1;
      oready[d] = 1'b1;
      hs[d]     = '0;
      for (int k = 0; k < N; k++) begin
        data[d][k] = (d == 0) ? 8'(8'h10 + k) : 8'(8'hA0 + k);
        rem[d][k]  = 0;
      end
    end

    // reset held with every channel requesting
    repeat (3) begin
      tick();
      #2;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d reset in_ready", d), int'(rdy[d]), 0);
        check($sformatf("d%0d reset out_valid", d), int'(ovalid[d]), 0);
        check($sformatf("d%0d reset out_data", d), int'(odata[d]), 0);
        check($sformatf("d%0d reset out_idx", d), int'(oidx[d]), 0);
      end
    end
    tick();
    rst_n = 1'b1;
    #2;
    check("d0 first grant", int'(rdy[0]), 1);
    check("d1 first grant", int'(rdy[1]), 1);

    // round-robin fairness continues from that first grant
    repeat (4) tick();
    tick();
    valid[0] = '0;
    valid[1] = '0;
    tick();
    tick();
    #2;
    e.delete();
    e.push_back('h0A0); e.push_back('h1A1); e.push_back('h2A2); e.push_back('h3A3); e.push_back('h0A0);
    check_log("rr fairness", log1, e);
    log0.delete();
    log1.delete();

    // fixed priority: ch1 beats ch3 until it drops
    tick();
    valid[0] = 4'b1010;
    tick();
    tick();
    tick();
    valid[0] = 4'b1000;
    tick();
    valid[0] = 4'b0000;
    tick();
    tick();
    #2;
    e.delete();
    e.push_back('h111); e.push_back('h111); e.push_back('h111); e.push_back('h313);
    check_log("fixed priority", log0, e);

    // packet lock: ch2 three beats with a bubble, ch0 waiting throughout
    tick();
    last[1]    = 4'b0001;
    data[1][0] = 8'hB0;
    data[1][2] = 8'hC0;
    valid[1]   = 4'b0101;
    #2;
    check("lock first grant", int'(rdy[1]), 4'b0100);
    tick();
    valid[1] = 4'b0001;
    #2;
    check("lock bubble", int'(rdy[1]), 0);
    tick();
    valid[1]   = 4'b0101;
    data[1][2] = 8'hC1;
    #2;
    check("lock beat 2", int'(rdy[1]), 4'b0100);
    tick();
    data[1][2] = 8'hC2;
    last[1][2] = 1'b1;
    #2;
    check("lock beat 3", int'(rdy[1]), 4'b0100);
    tick();
    valid[1] = 4'b0001;
    #2;
    check("after lock grant", int'(rdy[1]), 4'b0001);
    tick();
    valid[1] = '0;
    tick();
    tick();
    #2;
    e.delete();
    e.push_back('h2C0); e.push_back('h2C1); e.push_back('h2C2); e.push_back('h0B0);
    check_log("packet lock", log1, e);
    log1.delete();

    // backpressure: ch1 streams, consumer stalls for 4 cycles
    sent    = 0;
    last[1] = '1;
    for (int i = 0; i < 12; i++) begin
      tick();
      oready[1]  = !(i >= 3 && i <= 6);
      valid[1]   = 4'b0010;
      data[1][1] = 8'(8'hD0 + sent);
      #2;
      if (i >= 3 && i <= 6) check($sformatf("stall in_ready %0d", i), int'(rdy[1]), 0);
      if (rdy[1][1]) sent++;
    end
    tick();
    valid[1]  = '0;
    oready[1] = 1'b1;
    tick();
    tick();
    #2;
    check("backpressure beats sent", sent, 8);
    e.delete();
    for (int i = 0; i < 8; i++) e.push_back('h1D0 + i);
    check_log("backpressure", log1, e);
    log1.delete();

    // reset in the middle of a locked ch3 packet while ch1 waits
    tick();
    oready[1]  = 1'b0;
    last[1]    = 4'b0010;
    data[1][3] = 8'hE0;
    data[1][1] = 8'hF1;
    valid[1]   = 4'b1010;
    #2;
    check("mid-packet first grant", int'(rdy[1]), 4'b1000);
    tick();
    rst_n = 1'b0;
    #2;
    check("mid-packet reset ready", int'(rdy[1]), 0);
    tick();
    rst_n     = 1'b1;
    oready[1] = 1'b1;
    #2;
    check("mid-packet out_valid", int'(ovalid[1]), 0);
    check("mid-packet next grant", int'(rdy[1]), 4'b0010);
    tick();
    valid[1] = '0;
    tick();
    tick();
    #2;
    e.delete();
    e.push_back('h1F1);
    check_log("reset mid-packet", log1, e);

    // randomized traffic on both instances, then drain
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0;
      hs[d]    = '0;
      for (int k = 0; k < N; k++) rem[d][k] = 0;
    end
    repeat (600) rand_cycle();
    draining = 1'b1;
    done     = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      rand_cycle();
      done = (valid[0] == '0) && (valid[1] == '0) && !ovalid[0] && !ovalid[1];
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < N; k++)
          if (rem[d][k] != 0) done = 1'b0;
    end
    check("random drain completes", int'(done), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
